gamelogic_multi: RTL and testbench

GAMELOGIC_MULTI -- requirements
Module: gamelogic_multi

---
 rtl/gamelogic_multi.sv | 211 +++++++++++++++++++++
 tb/tb_gamelogic_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamelogic_multi.sv
// Multi-enemy combat logic: player attack hit-testing, per-enemy HP and respawn,
// player damage with invulnerability window, score and game-over freeze.
module gamelogic_multi #(
  parameter int N_ENEMY        = 4,
  parameter int ENEMY_HP       = 100,
  parameter int PLAYER_DMG     = 50,
  parameter int PLAYER_HP      = 200,
  parameter int ENEMY_DMG      = 10,
  parameter int RESPAWN_FRAMES = 100,
  parameter int INVULN_FRAMES  = 30,
  parameter int ATK_SHORT      = 16,
  parameter int ATK_LONG       = 80,
  parameter int ENEMY_W        = 26,
  parameter int ENEMY_H        = 26
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Frame_Tick,
  input  logic [8:0]             Attack_X,
  input  logic [8:0]             Attack_Y,
  input  logic [1:0]             Player_Direction,
  input  logic                   Attack_On,
  input  logic [9*N_ENEMY-1:0]   Enemy_X,
  input  logic [9*N_ENEMY-1:0]   Enemy_Y,
  input  logic [N_ENEMY-1:0]     Enemy_Attack_On,
  output logic [N_ENEMY-1:0]     Enemy_Alive,
  output logic [N_ENEMY-1:0]     Kill_Pulse,
  output logic [7:0]             Player_HP,
  output logic [7:0]             Score,
  output logic [9:0]             Total_Damage,
  output logic                   Game_Over
);

  localparam int RW = (RESPAWN_FRAMES < 1) ? 1 : $clog2(RESPAWN_FRAMES + 1);
  localparam int IW = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam int CW = $clog2(N_ENEMY + 1);

  localparam logic [6:0]  EHP     = 7'(ENEMY_HP);
  localparam logic [6:0]  PDMG    = 7'(PLAYER_DMG);
  localparam logic [7:0]  PHP     = 8'(PLAYER_HP);
  localparam logic [7:0]  EDMG    = 8'(ENEMY_DMG);
  localparam logic [10:0] EDMG11  = 11'(ENEMY_DMG);
  localparam logic [RW-1:0] RESP  = RW'(RESPAWN_FRAMES);
  localparam logic [IW-1:0] INV   = IW'(INVULN_FRAMES);
  localparam logic [10:0] S11     = 11'(ATK_SHORT);
  localparam logic [10:0] L11     = 11'(ATK_LONG);
  localparam logic [10:0] W11     = 11'(ENEMY_W);
  localparam logic [10:0] H11     = 11'(ENEMY_H);

  typedef enum logic {ALIVE, DEAD} estate_t;
  typedef enum logic [1:0] {DIR_DOWN, DIR_LEFT, DIR_UP, DIR_RIGHT} dir_t;

  estate_t         st_q   [N_ENEMY];
  estate_t         st_d   [N_ENEMY];
  logic [6:0]      hp_q   [N_ENEMY];
  logic [6:0]      hp_d   [N_ENEMY];
  logic [RW-1:0]   rc_q   [N_ENEMY];
  logic [RW-1:0]   rc_d   [N_ENEMY];
  logic [RW-1:0]   rc_inc [N_ENEMY];
  logic [10:0]     ex     [N_ENEMY];
  logic [10:0]     ey     [N_ENEMY];
  logic [N_ENEMY-1:0] kill_q, kill_d, hit;

  logic          atk_q, atk_d, atk_edge;
  logic [7:0]    php_q, php_d;
  logic [7:0]    score_q, score_d;
  logic [9:0]    td_q, td_d;
  logic [IW-1:0] inv_q, inv_d;
  logic          go_q, go_d;

  logic [10:0]   ax, ay;
  logic [10:0]   x_hi_ext, x_lo_ext, y_hi_ext, y_lo_ext;
  logic [CW-1:0] kcnt;
  logic [8:0]    score_sum;
  logic [10:0]   td_sum;

  assign ax       = {2'b00, Attack_X};
  assign ay       = {2'b00, Attack_Y};
  assign atk_edge = Attack_On & ~atk_q & ~go_q;

  // Rectangle extents relative to the anchor; low-side extents are added to the
  // enemy side of the compare instead of subtracted from the anchor, so nothing wraps.
  always_comb begin
    x_hi_ext = '0;
    x_lo_ext = '0;
    y_hi_ext = '0;
    y_lo_ext = '0;
    case (dir_t'(Player_Direction))
      DIR_DOWN:  begin x_hi_ext = S11; y_hi_ext = L11; end
      DIR_LEFT:  begin x_lo_ext = L11; y_hi_ext = S11; end
      DIR_UP:    begin x_hi_ext = S11; y_lo_ext = L11; end
      default:   begin x_hi_ext = L11; y_hi_ext = S11; end
    endcase
  end

  always_comb begin
    hit    = '0;
    kill_d = '0;
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      st_d[i]   = st_q[i];
      hp_d[i]   = hp_q[i];
      rc_d[i]   = rc_q[i];
      rc_inc[i] = rc_q[i] + 1'b1;
      ex[i]     = {2'b00, Enemy_X[9*i +: 9]};
      ey[i]     = {2'b00, Enemy_Y[9*i +: 9]};
      hit[i]    = atk_edge && (st_q[i] == ALIVE)
                  && (ex[i] <= ax + x_hi_ext) && (ex[i] + W11 + x_lo_ext >= ax)
                  && (ey[i] <= ay + y_hi_ext) && (ey[i] + H11 + y_lo_ext >= ay);
      if (!go_q) begin
        case (st_q[i])
          ALIVE: begin
            if (hp_q[i] == '0) begin
              st_d[i]   = DEAD;
              kill_d[i] = 1'b1;
              rc_d[i]   = '0;
            end else if (hit[i]) begin
              hp_d[i] = (hp_q[i] >= PDMG) ? hp_q[i] - PDMG : '0;
            end
          end
          default: begin
            if (Frame_Tick) begin
              if (rc_inc[i] == RESP) begin
                st_d[i] = ALIVE;
                hp_d[i] = EHP;
                rc_d[i] = '0;
              end else begin
                rc_d[i] = rc_inc[i];
              end
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    kcnt = '0;
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      kcnt = kcnt + CW'(kill_d[i]);
    end
    score_sum = {1'b0, score_q} + 9'(kcnt);
    score_d   = (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
  end

  always_comb begin
    php_d  = php_q;
    td_d   = td_q;
    inv_d  = inv_q;
    go_d   = go_q;
    atk_d  = atk_q;
    td_sum = {1'b0, td_q} + EDMG11;
    if (!go_q) begin
      atk_d = Attack_On;
      go_d  = (php_q == '0);
      if (Frame_Tick) begin
        // One damage event per tick however many enemies are touching.
        if (|(Enemy_Attack_On & Enemy_Alive) && inv_q == '0) begin
          php_d = (php_q >= EDMG) ? php_q - EDMG : '0;
          td_d  = (td_sum > 11'd1023) ? 10'd1023 : td_sum[9:0];
          inv_d = INV;
        end else if (inv_q != '0) begin
          inv_d = inv_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        st_q[i] <= ALIVE;
        hp_q[i] <= EHP;
        rc_q[i] <= '0;
      end
      kill_q  <= '0;
      atk_q   <= 1'b0;
      php_q   <= PHP;
      score_q <= '0;
      td_q    <= '0;
      inv_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        st_q[i] <= st_d[i];
        hp_q[i] <= hp_d[i];
        rc_q[i] <= rc_d[i];
      end
      kill_q  <= kill_d;
      atk_q   <= atk_d;
      php_q   <= php_d;
      score_q <= score_d;
      td_q    <= td_d;
      inv_q   <= inv_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    Enemy_Alive = '0;
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      Enemy_Alive[i] = (st_q[i] == ALIVE);
    end
  end

  assign Kill_Pulse   = kill_q;
  assign Player_HP    = php_q;
  assign Score        = score_q;
  assign Total_Damage = td_q;
  assign Game_Over    = go_q;

endmodule

// File: tb/tb_gamelogic_multi.sv
// Directed scoreboard bench for gamelogic_multi with default parameters.
module tb_gamelogic_multi;
  localparam int N = 4;

  logic           Clk = 1'b0;
  logic           Reset, Frame_Tick, Attack_On;
  logic [8:0]     Attack_X, Attack_Y;
  logic [1:0]     Player_Direction;
  logic [9*N-1:0] Enemy_X, Enemy_Y;
  logic [N-1:0]   Enemy_Attack_On, Enemy_Alive, Kill_Pulse;
  logic [7:0]     Player_HP, Score;
  logic [9:0]     Total_Damage;
  logic           Game_Over;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 Clk = ~Clk;

  gamelogic_multi #(.N_ENEMY(N)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Frame_Tick       (Frame_Tick),
    .Attack_X         (Attack_X),
    .Attack_Y         (Attack_Y),
    .Player_Direction (Player_Direction),
    .Attack_On        (Attack_On),
    .Enemy_X          (Enemy_X),
    .Enemy_Y          (Enemy_Y),
    .Enemy_Attack_On  (Enemy_Attack_On),
    .Enemy_Alive      (Enemy_Alive),
    .Kill_Pulse       (Kill_Pulse),
    .Player_HP        (Player_HP),
    .Score            (Score),
    .Total_Damage     (Total_Damage),
    .Game_Over        (Game_Over)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    Enemy_X[9*i +: 9] = 9'(x);
    Enemy_Y[9*i +: 9] = 9'(y);
  endtask

  task automatic park_all();
    for (int i = 0; i < N; i++) set_enemy(i, 400, 400);
  endtask

  task automatic set_attack(input int dir, input int x, input int y);
    Player_Direction = 2'(dir);
    Attack_X         = 9'(x);
    Attack_Y         = 9'(y);
  endtask

  task automatic attack();
    Attack_On = 1'b1;
    step(1);
    Attack_On = 1'b0;
    step(1);
  endtask

  task automatic watch(input int n, output logic [N-1:0] mask, output int pulses);
    mask   = '0;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      mask = mask | Kill_Pulse;
      if (Kill_Pulse != '0) pulses++;
      step(1);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      Frame_Tick = 1'b1;
      step(1);
      Frame_Tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] mask;
    int           pulses;
    int           tick_cnt;

    Reset = 1'b0; Frame_Tick = 1'b0; Attack_On = 1'b0;
    Enemy_Attack_On = '0;
    park_all();
    set_attack(3, 100, 100);
    step(2);

    // Reset state
    push("rst_alive", 4'hF); push("rst_kp", 0); push("rst_php", 200);
    push("rst_score", 0); push("rst_td", 0); push("rst_go", 0);
    do_reset();
    pop_check(Enemy_Alive); pop_check(Kill_Pulse); pop_check(Player_HP);
    pop_check(Score); pop_check(Total_Damage); pop_check(Game_Over);

    // Two hits kill E0 to the right of the anchor; pulse lands the cycle after HP=0
    set_enemy(0, 150, 105);
    push("k1_kp", 0); push("k1_alive", 4'hF);
    attack();
    pop_check(Kill_Pulse); pop_check(Enemy_Alive);
    push("k2_kp", 4'b0001); push("k2_alive", 4'b1110); push("k2_score", 1);
    attack();
    pop_check(Kill_Pulse); pop_check(Enemy_Alive); pop_check(Score);
    push("k2_kp_clear", 0);
    step(1);
    pop_check(Kill_Pulse);

    // Holding Attack_On counts as a single hit
    do_reset();
    Attack_On = 1'b1;
    step(20);
    Attack_On = 1'b0;
    step(1);
    push("hold_mask", 0); push("hold_alive", 4'hF);
    watch(3, mask, pulses);
    pop_check(mask); pop_check(Enemy_Alive);
    push("hold_kill_mask", 4'b0001); push("hold_kill_pulses", 1); push("hold_score", 1);
    attack();
    watch(3, mask, pulses);
    pop_check(mask); pop_check(pulses); pop_check(Score);

    // Left attack near the X origin must not wrap
    do_reset();
    park_all();
    set_attack(1, 10, 50);
    set_enemy(1, 0, 50);
    push("left_mask", 4'b0010); push("left_score", 1);
    attack(); attack();
    watch(3, mask, pulses);
    pop_check(mask); pop_check(Score);

    // Right attack from X=511 must not wrap onto an enemy at X=0
    do_reset();
    set_attack(3, 511, 50);
    push("right511_mask", 0); push("right511_score", 0); push("right511_alive", 4'hF);
    attack(); attack();
    watch(3, mask, pulses);
    pop_check(mask); pop_check(Score); pop_check(Enemy_Alive);

    // Edge-touching boxes hit, one pixel beyond misses; double kill in one cycle
    do_reset();
    park_all();
    set_attack(3, 100, 100);
    set_enemy(0, 74, 84);
    set_enemy(2, 180, 116);
    set_enemy(3, 181, 100);
    push("edge_first_mask", 0);
    attack();
    watch(2, mask, pulses);
    pop_check(mask);
    push("edge_kp", 4'b0101); push("edge_score", 2); push("edge_alive", 4'b1010);
    attack();
    pop_check(Kill_Pulse); pop_check(Score); pop_check(Enemy_Alive);

    // Respawn after exactly RESPAWN_FRAMES ticks; a same-cycle attack is ignored
    do_reset();
    park_all();
    set_enemy(0, 150, 105);
    attack(); attack();
    push("resp_dead", 4'b1110);
    pop_check(Enemy_Alive);
    ticks(99);
    push("resp_99", 4'b1110);
    pop_check(Enemy_Alive);
    Frame_Tick = 1'b1;
    Attack_On  = 1'b1;
    step(1);
    Frame_Tick = 1'b0;
    Attack_On  = 1'b0;
    push("resp_100", 4'hF);
    pop_check(Enemy_Alive);
    step(1);
    push("resp_hp_mask", 0); push("resp_hp_score", 1);
    attack();
    watch(3, mask, pulses);
    pop_check(mask); pop_check(Score);
    push("resp_rekill_mask", 4'b0001); push("resp_rekill_score", 2);
    attack();
    watch(3, mask, pulses);
    pop_check(mask); pop_check(Score);

    // Reset mid-respawn
    ticks(50);
    push("midresp_alive", 4'hF); push("midresp_score", 0);
    do_reset();
    pop_check(Enemy_Alive); pop_check(Score);

    // Player damage with invulnerability, down to Game_Over
    Enemy_Attack_On = '1;
    Frame_Tick      = 1'b1;
    push("dmg_php1", 190); push("dmg_td1", 10);
    step(1);
    pop_check(Player_HP); pop_check(Total_Damage);
    push("dmg_php31", 190);
    step(30);
    pop_check(Player_HP);
    push("dmg_php32", 180);
    step(1);
    pop_check(Player_HP);
    tick_cnt = 32;
    while (!Game_Over && tick_cnt < 2000) begin
      step(1);
      tick_cnt++;
    end
    push("go_tick", 591); push("go_php", 0); push("go_td", 200); push("go_flag", 1);
    pop_check(tick_cnt); pop_check(Player_HP); pop_check(Total_Damage); pop_check(Game_Over);

    // Frozen while Game_Over: no hits, kills or damage
    set_attack(3, 100, 100);
    attack(); attack();
    push("frz_mask", 0); push("frz_score", 0); push("frz_alive", 4'hF);
    push("frz_td", 200); push("frz_php", 0); push("frz_go", 1);
    watch(4, mask, pulses);
    pop_check(mask); pop_check(Score); pop_check(Enemy_Alive);
    pop_check(Total_Damage); pop_check(Player_HP); pop_check(Game_Over);

    // Reset out of Game_Over
    push("go_rst_php", 200); push("go_rst_go", 0); push("go_rst_td", 0);
    do_reset();
    pop_check(Player_HP); pop_check(Game_Over); pop_check(Total_Damage);
    Frame_Tick      = 1'b0;
    Enemy_Attack_On = '0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
